platform_runtime_sequencer: RTL

//  Game-runtime end of the platform ROM handshake. Keeps game time, drives the platform ROM reader's addr/current_time/sync_platform_time.

---
 rtl/platform_pkg.sv | 15 +
 rtl/platform_tick_timer.sv | 48 ++++
 rtl/platform_runtime_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/platform_pkg.sv
// Shared definitions for the platform ROM sequencer and the platform ROM reader.
package platform_pkg;

   localparam int unsigned ADDR_WIDTH_DEF    = 10;
   localparam int unsigned MAXIMUM_TIMES_DEF = 30;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StAck,
      StWait,
      StEnd
   } seq_state_e;

endpackage

// File: rtl/platform_tick_timer.sv
// Game-time base: a TICK_DIV prescaler feeding a free-running current_time counter.
module platform_tick_timer
   import platform_pkg::*;
#(
   parameter int unsigned MAXIMUM_TIMES = MAXIMUM_TIMES_DEF,
   parameter int unsigned TICK_DIV      = 250000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     run,
   output logic                     tick,
   output logic [MAXIMUM_TIMES-1:0] current_time
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0]            presc_q, presc_d;
   logic [MAXIMUM_TIMES-1:0] time_q, time_d;

   assign tick         = run && (presc_q == PW'(TICK_DIV - 1));
   assign current_time = time_q;

   always_comb begin
      presc_d = presc_q;
      time_d  = time_q;
      if (clear) begin
         presc_d = '0;
         time_d  = '0;
      end else if (tick) begin
         presc_d = '0;
         time_d  = time_q + MAXIMUM_TIMES'(1);
      end else if (run) begin
         presc_d = presc_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         presc_q <= '0;
         time_q  <= '0;
      end else begin
         presc_q <= presc_d;
         time_q  <= time_d;
      end
   end

endmodule

// File: rtl/platform_runtime_sequencer.sv
// Game-runtime side of the platform ROM handshake: steps entries in time order.
// Optional build macro PLATFORM_SEQ_LOOP_EN restarts the level from addr 0 after the last entry.
module platform_runtime_sequencer
   import platform_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int unsigned MAXIMUM_TIMES  = MAXIMUM_TIMES_DEF,
   parameter int unsigned NUM_ENTRIES    = 16,
   parameter int unsigned TICK_DIV       = 250000,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     pause,
   input  logic                     update_platform_time,
   input  logic [MAXIMUM_TIMES-1:0] next_platform_time,
   output logic [ADDR_WIDTH-1:0]    addr,
   output logic [MAXIMUM_TIMES-1:0] current_time,
   output logic                     sync_platform_time,
   output logic                     busy,
   output logic                     done,
   output logic                     error
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_ENTRIES - 1);

   seq_state_e               state_q, state_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [MAXIMUM_TIMES-1:0] due_q, due_d, time_diff;
   logic [TW-1:0]            tmo_q, tmo_d;
   logic                     busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic                     timer_clear, due_reached, tmo_hit, unused_tick;

   platform_tick_timer #(
      .MAXIMUM_TIMES (MAXIMUM_TIMES),
      .TICK_DIV      (TICK_DIV)
   ) u_timer (
      .clk          (clk),
      .reset        (reset),
      .clear        (timer_clear),
      .run          (busy_q && !pause),
      .tick         (unused_tick),
      .current_time (current_time)
   );

   // Wrap-safe "current_time >= due_q": the difference is non-negative within half the range.
   assign time_diff   = current_time - due_q;
   assign due_reached = ~time_diff[MAXIMUM_TIMES-1];
   assign tmo_hit     = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      due_d       = due_q;
      busy_d      = busy_q;
      done_d      = done_q;
      err_d       = err_q;
      timer_clear = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = StReq;
               addr_d      = '0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               err_d       = 1'b0;
               timer_clear = 1'b1;
            end
         end
         StReq: begin
`ifdef PLATFORM_SEQ_LOOP_EN
            done_d = 1'b0;
`endif
            if (update_platform_time) begin
               state_d = StAck;
               due_d   = next_platform_time;
            end else if (tmo_hit) begin
               state_d = StIdle;
               err_d   = 1'b1;
               busy_d  = 1'b0;
            end
         end
         StAck: begin
            if (!update_platform_time) begin
               if (addr_q == LastAddr) begin
                  state_d = StEnd;
               end else begin
                  addr_d  = addr_q + ADDR_WIDTH'(1);
                  state_d = StWait;
               end
            end else if (tmo_hit) begin
               state_d = StIdle;
               err_d   = 1'b1;
               busy_d  = 1'b0;
            end
         end
         StWait: begin
            if (due_reached) state_d = StReq;
         end
         StEnd: begin
            done_d = 1'b1;
`ifdef PLATFORM_SEQ_LOOP_EN
            addr_d  = '0;
            state_d = StReq;
`else
            busy_d  = 1'b0;
            state_d = StIdle;
`endif
         end
         default: state_d = StIdle;
      endcase

      if (state_d != state_q) begin
         tmo_d = '0;
      end else if (state_q == StReq || state_q == StAck) begin
         tmo_d = tmo_q + TW'(1);
      end else begin
         tmo_d = tmo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         due_q   <= '0;
         tmo_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         due_q   <= due_d;
         tmo_q   <= tmo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign addr               = addr_q;
   assign sync_platform_time = (state_q != StReq);
   assign busy               = busy_q;
   assign done               = done_q;
   assign error              = err_q;

endmodule
